// File: rtl/dcache_write_buffer_pkg.sv
// rtl/dcache_write_buffer_pkg.sv - shared widths and memory-FSM state encoding for the D-cache write buffer
// Purpose: default block address/data widths and the memory FSM states,
//          shared by dcache_write_buffer and wb_fifo_cam.
// Ports:   none (package).
package dcache_write_buffer_pkg;

  localparam int AW_DEF = 28;   // block address bits [31:4]
  localparam int DW_DEF = 128;  // one cache block

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_READ  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/wb_fifo_cam.sv
// rtl/wb_fifo_cam.sv - block FIFO with head/tail/count and youngest-match address search
// Purpose: holds queued writeback blocks in arrival order and answers
//          "which is the youngest valid entry at this address" for read hits.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   push, push_addr/data    append an entry at the tail
//   pop                     retire the head entry
//   head_addr, head_data    oldest entry (next to drain)
//   count                   number of valid entries, 0..DEPTH
//   lookup_addr             address to search
//   hit, hit_data           youngest matching valid entry
module wb_fifo_cam #(
  parameter int DEPTH = 2,
  parameter int AW    = 28,
  parameter int DW    = 128,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [DW-1:0] hit_data
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    tail_ptr;
  logic [PW-1:0]    idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      valid_q  <= '0;
    end else begin
      if (push) begin
        valid_q[tail_ptr] <= 1'b1;
        tail_ptr          <= tail_ptr + PW'(1);
      end
      if (pop) begin
        valid_q[head_ptr] <= 1'b0;
        head_ptr          <= head_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload needs no reset: valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_ptr] <= push_addr;
      data_q[tail_ptr] <= push_data;
    end
  end

  assign head_addr = addr_q[head_ptr];
  assign head_data = data_q[head_ptr];

  // Walk from oldest to youngest; the last match found is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - posted-write buffer between D-cache and data-side slow memory
// Purpose: accepts dirty-block writebacks in one cycle, drains them to slow
//          memory in the background, lets read misses bypass queued writes
//          and serves reads that match a queued block from the buffer.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   c_read, c_write, c_addr, c_wdata    cache request, held until c_ready
//   c_rdata, c_ready                    read data and one-cycle completion pulse
//   mem_read, mem_write, mem_addr,
//   mem_wdata                           slow-memory request, held until mem_ready
//   mem_rdata, mem_ready                slow-memory response
//   wb_empty                            nothing queued and memory FSM idle
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_read,
  input  logic          c_write,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ready,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          wb_empty
);

  localparam int CW = $clog2(DEPTH + 1);

  mem_state_e    state;
  logic          rd_pending;
  logic          push;
  logic          pop;
  logic          lookup;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [CW-1:0] count;

  // A request is only looked at while no completion pulse is showing and no
  // read miss is already waiting on memory.
  assign push   = c_write && !c_ready && !rd_pending && (count < CW'(DEPTH));
  assign lookup = c_read  && !c_ready && !rd_pending;
  assign pop    = (state == ST_DRAIN) && mem_ready;

  wb_fifo_cam #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_addr   (c_addr),
    .push_data   (c_wdata),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (count),
    .lookup_addr (c_addr),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  // Cache-side handshake: write accept, read hit, and read-miss completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_ready    <= 1'b0;
      c_rdata    <= '0;
      rd_pending <= 1'b0;
    end else begin
      c_ready <= 1'b0;
      if (push) begin
        c_ready <= 1'b1;
      end else if (lookup) begin
        if (hit) begin
          c_rdata <= hit_data;
          c_ready <= 1'b1;
        end else begin
          rd_pending <= 1'b1;
        end
      end
      if ((state == ST_READ) && mem_ready) begin
        c_rdata    <= mem_rdata;
        c_ready    <= 1'b1;
        rd_pending <= 1'b0;
      end
    end
  end

  // Memory FSM. A pending read miss wins over draining whenever the FSM is
  // idle, so a miss that arrives mid-drain goes next. wb_empty is computed
  // from the post-edge count and state so it stays a clean register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_empty  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_pending) begin
            state    <= ST_READ;
            mem_read <= 1'b1;
            mem_addr <= c_addr;
            wb_empty <= 1'b0;
          end else if (count != '0) begin
            state     <= ST_DRAIN;
            mem_write <= 1'b1;
            mem_addr  <= head_addr;
            mem_wdata <= head_data;
            wb_empty  <= 1'b0;
          end else begin
            wb_empty <= !push;
          end
        end
        ST_DRAIN: begin
          if (mem_ready) begin
            state     <= ST_IDLE;
            mem_write <= 1'b0;
            wb_empty  <= (count == CW'(1)) && !push;
          end
        end
        ST_READ: begin
          if (mem_ready) begin
            state    <= ST_IDLE;
            mem_read <= 1'b0;
            wb_empty <= (count == '0) && !push;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb/tb_dcache_write_buffer.sv - self-checking bench for dcache_write_buffer
module tb_dcache_write_buffer;

  localparam int DEPTH = 2;
  localparam int AW    = 28;
  localparam int DW    = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c_read, c_write;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          wb_empty;

  dcache_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c_read    (c_read),
    .c_write   (c_write),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .c_ready   (c_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .wb_empty  (wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t        wbq[$];      // reference: queued-but-not-retired writes, oldest first
  logic [AW:0] oplog[$];    // {is_write, addr} of every completed memory access
  int          wr_pulses[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          mem_hold = 1'b0;
  int          wait_cnt = 0;
  int          lat      = 0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  int          drains    = 0;
  int          rd_served = 0;
  int          rd_pulse_cyc = 0;
  logic [DW-1:0] last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slow-memory responder: random 0..3 cycle latency, optional hold, and a
  // check of every drained block against the head of the reference queue.
  initial begin
    bit pop_it;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      pop_it    = 1'b0;
      if (!rst_n) begin
        wait_cnt = 0;
      end else begin
        chk("mem_rw_exclusive", mem_read && mem_write, 1'b0);
        if (mem_read)  rd_cycles++;
        if (mem_write) wr_cycles++;
        if ((mem_read || mem_write) && !mem_hold) begin
          if (wait_cnt >= lat) begin
            mem_ready = 1'b1;
            wait_cnt  = 0;
            lat       = $urandom_range(0, 3);
            if (mem_write) begin
              oplog.push_back({1'b1, mem_addr});
              wr_pulses.push_back(cyc);
              drains++;
              chk("drain_has_entry", wbq.size() > 0, 1'b1);
              if (wbq.size() > 0) begin
                chk("drain_addr", mem_addr, wbq[0].a);
                chk("drain_data", mem_wdata, wbq[0].d);
                pop_it = 1'b1;
              end
            end else begin
              mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
              last_rdata = mem_rdata;
              rd_served++;
              rd_pulse_cyc = cyc;
              oplog.push_back({1'b0, mem_addr});
            end
            @(posedge clk);
            if (pop_it) void'(wbq.pop_front());
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  task automatic wait_ready(input int bound, output int l);
    l = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (c_ready) begin
        l = i;
        break;
      end
    end
    chk("ready_seen", c_ready, 1'b1);
  endtask

  task automatic wait_empty(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (wb_empty) break;
    end
    chk(tag, wb_empty, 1'b1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    int l;
    bit notfull;
    notfull = wbq.size() < DEPTH;
    c_write = 1'b1;
    c_addr  = a;
    c_wdata = d;
    wait_ready(400, l);
    c_write = 1'b0;
    wbq.push_back({a, d});
    if (notfull) chk({tag, "_lat"}, l, 1);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input string tag);
    int l;
    int rs;
    bit exp_hit;
    logic [DW-1:0] exp_d;
    exp_hit = 1'b0;
    exp_d   = '0;
    foreach (wbq[i]) if (wbq[i].a == a) begin exp_hit = 1'b1; exp_d = wbq[i].d; end
    rs     = rd_served;
    c_read = 1'b1;
    c_addr = a;
    wait_ready(400, l);
    if (exp_hit) begin
      chk({tag, "_hit_lat"}, l, 1);
      chk({tag, "_hit_data"}, c_rdata, exp_d);
      chk({tag, "_hit_nomem"}, rd_served, rs);
    end else begin
      chk({tag, "_miss_data"}, c_rdata, last_rdata);
      chk({tag, "_miss_memrd"}, rd_served, rs + 1);
      chk({tag, "_miss_addr"}, oplog[oplog.size()-1], {1'b0, a});
    end
    c_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int l, rc, wc, k, wr_total;
    logic [DW-1:0] x, y;
    rst_n   = 1'b0;
    c_read  = 1'b0;
    c_write = 1'b0;
    c_addr  = '0;
    c_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_c_ready", c_ready, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_wb_empty", wb_empty, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset in the middle of a drain
    mem_hold = 1'b1;
    do_write(28'h5, {$urandom, $urandom, $urandom, $urandom}, "t1_wr");
    for (int i = 0; i < 10 && !mem_write; i++) @(negedge clk);
    chk("t1_drain_started", mem_write, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_mem_write", mem_write, 1'b0);
    chk("t1_mem_read", mem_read, 1'b0);
    chk("t1_c_ready", c_ready, 1'b0);
    chk("t1_mem_addr", mem_addr, '0);
    chk("t1_mem_wdata", mem_wdata, '0);
    chk("t1_c_rdata", c_rdata, '0);
    chk("t1_wb_empty", wb_empty, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wbq.delete();
    mem_hold = 1'b0;
    rc = rd_cycles;
    wc = wr_cycles;
    repeat (10) @(negedge clk);
    chk("t1_no_mem_rd", rd_cycles, rc);
    chk("t1_no_mem_wr", wr_cycles, wc);
    chk("t1_still_empty", wb_empty, 1'b1);

    // 2: single write drains
    k = drains;
    do_write(28'h10, {4{32'h11111111}}, "t2_wr");
    wait_empty("t2_empty", 50);
    chk("t2_drains", drains, k + 1);
    chk("t2_op", oplog[oplog.size()-1], {1'b1, 28'h10});

    // 3: fill, stall on full, in-order drain
    mem_hold = 1'b1;
    do_write(28'h10, {$urandom, $urandom, $urandom, $urandom}, "t3_wr10");
    do_write(28'h20, {$urandom, $urandom, $urandom, $urandom}, "t3_wr20");
    x = {$urandom, $urandom, $urandom, $urandom};
    c_write = 1'b1;
    c_addr  = 28'h30;
    c_wdata = x;
    repeat (5) @(negedge clk);
    chk("t3_stalled", c_ready, 1'b0);
    k = wr_pulses.size();
    mem_hold = 1'b0;
    wait_ready(50, l);
    chk("t3_accept_cycle", cyc, (wr_pulses.size() > k) ? wr_pulses[k] + 2 : -1);
    c_write = 1'b0;
    wbq.push_back({28'h30, x});
    @(negedge clk);
    wait_empty("t3_empty", 100);
    chk("t3_order0", oplog[oplog.size()-3], {1'b1, 28'h10});
    chk("t3_order1", oplog[oplog.size()-2], {1'b1, 28'h20});
    chk("t3_order2", oplog[oplog.size()-1], {1'b1, 28'h30});

    // 4: youngest duplicate wins, no memory read
    mem_hold = 1'b1;
    x = {$urandom, $urandom, $urandom, $urandom};
    y = ~x;
    do_write(28'h10, x, "t4_wrx");
    do_write(28'h10, y, "t4_wry");
    rc = rd_cycles;
    do_read(28'h10, "t4_rd");
    chk("t4_data_is_y", c_rdata, y);
    chk("t4_no_mem_read", rd_cycles, rc);
    mem_hold = 1'b0;
    wait_empty("t4_empty", 100);

    // 5: read miss during drain waits for drain, then reads
    mem_hold = 1'b1;
    do_write(28'h10, {$urandom, $urandom, $urandom, $urandom}, "t5_wr");
    for (int i = 0; i < 10 && !mem_write; i++) @(negedge clk);
    c_read = 1'b1;
    c_addr = 28'h40;
    repeat (3) @(negedge clk);
    mem_hold = 1'b0;
    wait_ready(50, l);
    chk("t5_rdata", c_rdata, last_rdata);
    chk("t5_ready_cycle", cyc, rd_pulse_cyc + 1);
    chk("t5_order0", oplog[oplog.size()-2], {1'b1, 28'h10});
    chk("t5_order1", oplog[oplog.size()-1], {1'b0, 28'h40});
    c_read = 1'b0;
    @(negedge clk);
    wait_empty("t5_empty", 100);

    // 6: pending read miss beats the next queued drain
    mem_hold = 1'b1;
    do_write(28'h60, {$urandom, $urandom, $urandom, $urandom}, "t6_wr60");
    do_write(28'h70, {$urandom, $urandom, $urandom, $urandom}, "t6_wr70");
    for (int i = 0; i < 10 && !mem_write; i++) @(negedge clk);
    c_read = 1'b1;
    c_addr = 28'h80;
    repeat (3) @(negedge clk);
    mem_hold = 1'b0;
    wait_ready(50, l);
    chk("t6_rdata", c_rdata, last_rdata);
    c_read = 1'b0;
    @(negedge clk);
    wait_empty("t6_empty", 100);
    chk("t6_order0", oplog[oplog.size()-3], {1'b1, 28'h60});
    chk("t6_order1", oplog[oplog.size()-2], {1'b0, 28'h80});
    chk("t6_order2", oplog[oplog.size()-1], {1'b1, 28'h70});

    // Random mix against the reference queue
    k = drains;
    wr_total = 0;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write(28'h100 + 28'($urandom_range(0, 7)),
                 {$urandom, $urandom, $urandom, $urandom}, "rnd_wr");
        wr_total++;
      end else begin
        do_read(28'h100 + 28'($urandom_range(0, 11)), "rnd_rd");
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_empty("rnd_empty", 200);
    chk("rnd_drain_count", drains, k + wr_total);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
- Posted-write buffer between the D-cache miss/writeback port and the data-side slow_memory.
- Dirty-block writebacks are accepted in one cycle and queued, then drained to slow memory in the background.
- Read misses bypass queued writes. A read that matches a queued block is served directly from the buffer, with no memory access.
- One instance per CHIP, on the data side only. The instruction side stays directly connected.

Parameters:
- DEPTH, 2, number of buffered 128-bit blocks; power of two, at least 2.
- AW, 28, block address width (address bits [31:4]).
- DW, 128, block data width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- c_read  in  1  cache read request; held until c_ready
- c_write  in  1  cache write (writeback) request; held until c_ready
- c_addr  in  AW  cache block address
- c_wdata  in  DW  cache writeback data
- c_rdata  out  DW  read data, valid while c_ready=1
- c_ready  out  1  one-cycle completion pulse to the cache
- mem_read  out  1  slow-memory read request
- mem_write  out  1  slow-memory write request
- mem_addr  out  AW  slow-memory block address
- mem_wdata  out  DW  slow-memory write data
- mem_rdata  in  DW  slow-memory read data
- mem_ready  in  1  slow-memory completion pulse
- wb_empty  out  1  buffer holds no entries and no drain is in flight

Behaviour:
Cache side:
- All outputs are registered.
- c_read and c_write are never both high. A request is sampled only while c_ready=0 and no cache-side request is in service.
- The cache drops its request in the cycle after c_ready.

Write path:
- Condition: c_write and count<DEPTH.
- Entry is pushed at the tail: {addr, data}.
- c_ready=1 in the next cycle.
- If the buffer is full, the write stalls until a drain retires an entry. The freed slot is usable from the cycle after the retiring mem_ready.
- No coalescing; duplicate addresses may coexist.

Read path (address CAM over all valid entries, including the entry being drained):
- Hit: c_rdata = data of the youngest matching entry; c_ready=1 in the next cycle; no memory access.
- Miss: the memory FSM issues the read. When mem_ready arrives, mem_rdata is registered into c_rdata and c_ready=1 in the following cycle.

Memory FSM: IDLE, DRAIN, READ.
- IDLE → READ when a read miss is pending. This has priority over draining.
- IDLE → DRAIN when count>0 and no read miss is pending. mem_addr/mem_wdata are taken from the head entry.
- DRAIN → IDLE on mem_ready. The head is popped in that same cycle.
- READ → IDLE on mem_ready.
- A read miss that arrives during DRAIN waits for the drain to complete. It is then serviced before the next drain.

Memory-side signalling:
- mem_read and mem_write are asserted from the cycle after the state is entered, held stable until mem_ready, and deasserted in the cycle after mem_ready.
- They are never both high.

Simultaneous events:
- A write push and a drain pop in the same cycle leave count unchanged.
- The CAM compare uses pre-pop contents.
- A read-hit check in the same cycle as a write push does not see the new entry. Reads and writes are serialised by the cache anyway.

Pointers and status:
- Head and tail pointers are log2(DEPTH) bits wide, wrap modulo DEPTH, and count runs 0..DEPTH.
- wb_empty = (count==0) && state==IDLE.

Reset (asynchronous, any time):
- state=IDLE, pointers and count=0, valid bits cleared.
- c_ready, mem_read, mem_write = 0; c_rdata, mem_addr, mem_wdata = 0; wb_empty=1.
- In-flight and queued writes are discarded.

Decomposition:
- Shared package holds: AW/DW defaults, and FSM state encodings (IDLE=2'd0, DRAIN=2'd1, READ=2'd2).
- One sub-module: wb_fifo_cam, which contains the storage, head/tail/count and the youngest-match search.
- The top level holds the cache-side handshake and the memory FSM.

Test Plan:
1. Reset mid-drain: assert rst_n=0 while mem_write=1 → all outputs drop within the same cycle; wb_empty=1; after release, no memory access occurs without a new request.
2. Write A=28'h0000010, data=128'h1111…1111 → c_ready in cycle+1; then mem_write with that addr/data; wb_empty=1 after mem_ready.
3. Two writes, 28'h10 then 28'h20, with slow memory stalled → both accepted in 1 cycle each. A third write, 28'h30, stalls until the first drain's mem_ready; drain order is 10, 20, 30.
4. Write 28'h10=X then 28'h10=Y; read 28'h10 before drain → c_rdata=Y, c_ready at cycle+1, mem_read never asserted.
5. Write 28'h10, then immediately read miss 28'h40 while drain of 28'h10 is in flight → mem_write completes first, then mem_read 28'h40; c_ready one cycle after its mem_ready, with c_rdata=mem_rdata.
6. Read miss with an empty buffer and a pending write queued behind it → READ precedes DRAIN; mem_read and mem_write never both high at any cycle (checked by assertion).
